// File: rtl/ecc_core.sv
// ecc_core: extended-Hamming SECDED encoder/decoder for 8/16/32-bit codewords.
// An operation is requested with start in IDLE. The operands are captured on
// that edge, processed in ENC and/or DEC, and the result is registered on entry
// to DONE, which raises operation_done for one cycle.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-low reset
//   start               level request, sampled only while idle
//   CTRL[1:0]           0 encode, 1 decode, 2 full channel (encode+noise+decode), 3 invalid
//   DATA_IN             raw data (encode/full) or received codeword (decode)
//   CODEWORD_WIDTH[1:0] 0 -> 8, 1 -> 16, 2 -> 32, 3 invalid
//   NOISE               error mask applied to the codeword in full-channel mode
//   data_out            registered result, right-justified, zero-extended
//   num_of_errors       0, 1 or 2 (2 = uncorrectable); 0 for encode
//   operation_done      one-cycle pulse while the result is presented
//   busy                high in every state except IDLE
module ecc_core #(
    parameter int unsigned AMBA_WORD = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [AMBA_WORD-1:0] CTRL,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [AMBA_WORD-1:0] CODEWORD_WIDTH,
    input  logic [AMBA_WORD-1:0] NOISE,
    output logic [AMBA_WORD-1:0] data_out,
    output logic [1:0]           num_of_errors,
    output logic                 operation_done,
    output logic                 busy
);

    typedef enum logic [2:0] {S_IDLE, S_CAPTURE, S_ENC, S_DEC, S_DONE} state_t;

    typedef struct packed {
        logic [1:0]  nerr;
        logic [31:0] data;
    } dec_t;

    function automatic int unsigned cw_bits(input logic [1:0] wsel);
        return (wsel == 2'd0) ? 8 : (wsel == 2'd1) ? 16 : 32;
    endfunction

    // Data bits fill the non-power-of-two positions; each parity bit is then
    // the matching bit of the XOR of all set data positions.
    function automatic logic [31:0] hamming_encode(input logic [31:0] d, input logic [1:0] wsel);
        int unsigned w;
        int unsigned j;
        logic [31:0] cw;
        logic [4:0]  s;
        w  = cw_bits(wsel);
        cw = '0;
        s  = '0;
        j  = 0;
        for (int unsigned pos = 1; pos < 32; pos++) begin
            if (pos < w && (pos & (pos - 1)) != 0) begin
                cw[5'(pos - 1)] = d[5'(j)];
                if (d[5'(j)]) s ^= 5'(pos);
                j++;
            end
        end
        for (int unsigned k = 0; k < 5; k++) begin
            if ((32'd1 << k) < w) cw[5'((32'd1 << k) - 1)] = s[3'(k)];
        end
        cw[5'(w - 1)] = ^cw;
        return cw;
    endfunction

    function automatic dec_t hamming_decode(input logic [31:0] cw_in, input logic [1:0] wsel);
        int unsigned w;
        int unsigned j;
        logic [31:0] cw;
        logic [4:0]  s;
        logic        par;
        dec_t        r;
        w  = cw_bits(wsel);
        cw = (w == 32) ? cw_in : (cw_in & ((32'd1 << w) - 32'd1));
        s  = '0;
        for (int unsigned pos = 1; pos < 32; pos++) begin
            if (pos < w && cw[5'(pos - 1)]) s ^= 5'(pos);
        end
        par = ^cw;
        r   = '0;
        if (par) begin
            r.nerr = 2'd1;
            // A zero syndrome with odd parity means the overall parity bit itself flipped.
            if (s == '0) cw[5'(w - 1)] = ~cw[5'(w - 1)];
            else         cw[s - 5'd1]  = ~cw[s - 5'd1];
        end else if (s != '0) begin
            r.nerr = 2'd2;
        end
        j = 0;
        for (int unsigned pos = 1; pos < 32; pos++) begin
            if (pos < w && (pos & (pos - 1)) != 0) begin
                r.data[5'(j)] = cw[5'(pos - 1)];
                j++;
            end
        end
        return r;
    endfunction

    state_t         state_q, state_d;
    logic [1:0]     ctrl_q, width_q;
    logic [31:0]    data_q, noise_q, cw_q;
    logic [AMBA_WORD-1:0] data_out_q;
    logic [1:0]     nerr_q;
    logic           done_q;

    logic           invalid;
    logic [31:0]    enc_cw, dec_in, res_data;
    logic [1:0]     res_nerr;
    dec_t           dec_res;

    logic unused_ok;
    assign unused_ok = ^{CTRL[AMBA_WORD-1:2], CODEWORD_WIDTH[AMBA_WORD-1:2]};

    assign invalid = (ctrl_q == 2'd3) || (width_q == 2'd3);
    assign enc_cw  = hamming_encode(data_q, width_q);
    // Full channel decodes the encoded word from ENC; plain decode uses the captured input.
    assign dec_in  = (ctrl_q == 2'd2) ? (cw_q ^ noise_q) : data_q;
    assign dec_res = hamming_decode(dec_in, width_q);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (start) state_d = S_CAPTURE;
            S_CAPTURE: begin
                if (invalid)               state_d = S_DONE;
                else if (ctrl_q == 2'd1)   state_d = S_DEC;
                else                       state_d = S_ENC;
            end
            S_ENC:     state_d = (ctrl_q == 2'd2) ? S_DEC : S_DONE;
            S_DEC:     state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        res_data = '0;
        res_nerr = '0;
        if (state_q == S_ENC) begin
            res_data = enc_cw;
        end else if (state_q == S_DEC) begin
            res_data = dec_res.data;
            res_nerr = dec_res.nerr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            ctrl_q     <= '0;
            width_q    <= '0;
            data_q     <= '0;
            noise_q    <= '0;
            cw_q       <= '0;
            data_out_q <= '0;
            nerr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_d == S_DONE);
            if (state_q == S_IDLE && start) begin
                ctrl_q  <= CTRL[1:0];
                width_q <= CODEWORD_WIDTH[1:0];
                data_q  <= DATA_IN[31:0];
                noise_q <= NOISE[31:0];
            end
            if (state_q == S_ENC) cw_q <= enc_cw;
            if (state_d == S_DONE) begin
                data_out_q <= AMBA_WORD'(res_data);
                nerr_q     <= res_nerr;
            end
        end
    end

    assign data_out       = data_out_q;
    assign num_of_errors  = nerr_q;
    assign operation_done = done_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ecc_core.sv
// Testbench for ecc_core: directed cases plus randomized operations compared
// against a behavioural SECDED model built from the code definition
// (parity by address bits, decode by nearest valid codeword).
module tb_ecc_core;
    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] CTRL = '0, DATA_IN = '0, CODEWORD_WIDTH = '0, NOISE = '0;
    logic [AW-1:0] data_out;
    logic [1:0]    num_of_errors;
    logic          operation_done, busy;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    ecc_core #(.AMBA_WORD(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .CTRL(CTRL), .DATA_IN(DATA_IN),
        .CODEWORD_WIDTH(CODEWORD_WIDTH), .NOISE(NOISE), .data_out(data_out),
        .num_of_errors(num_of_errors), .operation_done(operation_done), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_p2(input int unsigned p);
        return (p & (p - 1)) == 0;
    endfunction

    function automatic int unsigned wbits(input logic [1:0] s);
        return (s == 0) ? 8 : (s == 1) ? 16 : 32;
    endfunction

    function automatic logic [31:0] wmask(input int unsigned w);
        return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] d, input int unsigned w);
        logic [31:0] cw;
        int unsigned j;
        logic x;
        cw = '0;
        j = 0;
        for (int unsigned p = 1; p < w; p++)
            if (!is_p2(p)) begin cw[p-1] = d[j]; j++; end
        for (int unsigned b = 1; b < w; b = b * 2) begin
            x = 1'b0;
            for (int unsigned q = 1; q < w; q++)
                if ((q & b) != 0) x ^= cw[q-1];
            cw[b-1] = x;
        end
        cw[w-1] = ^cw;
        return cw;
    endfunction

    function automatic logic [31:0] m_ext(input logic [31:0] cw, input int unsigned w);
        logic [31:0] d;
        int unsigned j;
        d = '0;
        j = 0;
        for (int unsigned p = 1; p < w; p++)
            if (!is_p2(p)) begin d[j] = cw[p-1]; j++; end
        return d;
    endfunction

    function automatic bit m_valid(input logic [31:0] cw, input int unsigned w);
        return m_enc(m_ext(cw, w), w) == cw;
    endfunction

    // Nearest-codeword decode: distance 0 -> clean, distance 1 -> corrected, else 2.
    task automatic m_dec(input logic [31:0] cw_in, input int unsigned w,
                         output logic [31:0] d, output logic [1:0] ne);
        logic [31:0] cw, t;
        cw = cw_in & wmask(w);
        d  = m_ext(cw, w);
        ne = 2'd2;
        if (m_valid(cw, w)) begin
            ne = 2'd0;
        end else begin
            for (int unsigned b = 0; b < w; b++) begin
                t = cw ^ (32'd1 << b);
                if (m_valid(t, w)) begin d = m_ext(t, w); ne = 2'd1; end
            end
        end
    endtask

    // ---------------- operation driver ----------------
    task automatic run_op(input logic [1:0] c, input logic [1:0] ws,
                          input logic [31:0] d, input logic [31:0] n, input string tag);
        logic [31:0] exp_d;
        logic [1:0]  exp_n;
        int unsigned lat, k, w;
        w = wbits(ws);
        exp_d = '0;
        exp_n = '0;
        if (c == 3 || ws == 3) lat = 2;
        else if (c == 0) begin lat = 3; exp_d = m_enc(d, w); end
        else if (c == 1) begin lat = 3; m_dec(d, w, exp_d, exp_n); end
        else begin lat = 4; m_dec(m_enc(d, w) ^ n, w, exp_d, exp_n); end

        @(negedge clk);
        CTRL = $urandom;  CTRL[1:0] = c;
        CODEWORD_WIDTH = $urandom;  CODEWORD_WIDTH[1:0] = ws;
        DATA_IN = d;
        NOISE = n;
        start = 1'b1;
        @(posedge clk);
        k = 1;
        while (1) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (k == 2) begin
                CTRL = $urandom; DATA_IN = $urandom;
                CODEWORD_WIDTH = $urandom; NOISE = $urandom;
            end
            if (operation_done || k >= 8) break;
            @(posedge clk);
            k++;
        end
        check({tag, " done"}, 32'(operation_done), 32'd1);
        check({tag, " latency"}, k, lat);
        check({tag, " data_out"}, data_out, exp_d);
        check({tag, " nerr"}, 32'(num_of_errors), 32'(exp_n));
        check({tag, " busy@done"}, 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        check({tag, " done pulse"}, 32'(operation_done), 32'd0);
        check({tag, " idle"}, 32'(busy), 32'd0);
        check({tag, " hold"}, data_out, exp_d);
    endtask

    initial begin
        int unsigned dq[$];
        int unsigned w, nf, b1, b2;
        logic [1:0] c, ws;
        logic [31:0] d, n, m;

        // Asynchronous reset, checked before any clock edge.
        #2 rst = 1'b0;
        #1;
        check("rst data_out", data_out, 32'd0);
        check("rst nerr", 32'(num_of_errors), 32'd0);
        check("rst done", 32'(operation_done), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed vectors.
        run_op(2'd0, 2'd0, 32'hB,  32'h0,  "enc8 0xB");
        check("enc8 0xB literal", data_out, 32'h55);
        run_op(2'd0, 2'd0, 32'hF,  32'h0,  "enc8 0xF");
        check("enc8 0xF literal", data_out, 32'hFF);
        run_op(2'd1, 2'd0, 32'h51, 32'h0,  "dec8 0x51");
        check("dec8 0x51 literal", data_out, 32'hB);
        run_op(2'd1, 2'd0, 32'h56, 32'h0,  "dec8 0x56");
        check("dec8 0x56 nerr literal", 32'(num_of_errors), 32'd2);
        run_op(2'd2, 2'd0, 32'hB,  32'h10, "full8 noise");
        check("full8 literal", data_out, 32'hB);
        run_op(2'd1, 2'd0, 32'h55, 32'h0,  "dec8 clean");
        run_op(2'd1, 2'd0, 32'hD5, 32'h0,  "dec8 parity bit");
        run_op(2'd3, 2'd0, 32'hB,  32'h0,  "invalid ctrl");
        run_op(2'd0, 2'd3, 32'hB,  32'h0,  "invalid width");
        run_op(2'd0, 2'd2, 32'hFFFF_FFFF, 32'h0, "enc32 ones");
        run_op(2'd2, 2'd1, 32'h7FF, 32'h0000_8001, "full16 2err");

        // Start held high: a second operation starts in the IDLE cycle after DONE.
        @(negedge clk);
        CTRL = 32'h0; CODEWORD_WIDTH = 32'h0; DATA_IN = 32'hF; NOISE = 32'h0;
        start = 1'b1;
        @(posedge clk);
        for (int unsigned k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (operation_done) dq.push_back(k);
            @(posedge clk);
        end
        @(negedge clk);
        start = 1'b0;
        check("b2b pulses", dq.size(), 2);
        if (dq.size() >= 2) begin
            check("b2b first", dq[0], 3);
            check("b2b second", dq[1], 7);
        end
        repeat (6) @(negedge clk);
        check("b2b data", data_out, 32'hFF);
        check("b2b idle", 32'(busy), 32'd0);

        // Reset during DEC aborts with no done pulse.
        @(negedge clk);
        CTRL = 32'h1; CODEWORD_WIDTH = 32'h0; DATA_IN = 32'h51;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("abort data_out", data_out, 32'd0);
        check("abort nerr", 32'(num_of_errors), 32'd0);
        check("abort busy", 32'(busy), 32'd0);
        check("abort done", 32'(operation_done), 32'd0);
        repeat (3) begin
            @(negedge clk);
            check("abort no pulse", 32'(operation_done), 32'd0);
        end
        rst = 1'b1;
        run_op(2'd0, 2'd0, 32'hB, 32'h0, "post-reset enc8");
        check("post-reset literal", data_out, 32'h55);

        // Randomized operations.
        for (int i = 0; i < 60; i++) begin
            c  = 2'($urandom_range(0, 2));
            ws = 2'($urandom_range(0, 2));
            if ($urandom_range(0, 9) == 0) c = 2'd3;
            if ($urandom_range(0, 9) == 0) ws = 2'd3;
            w  = wbits(ws);
            m  = wmask(w);
            d  = $urandom;
            n  = '0;
            nf = $urandom_range(0, 2);
            b1 = $urandom_range(0, w - 1);
            b2 = (b1 + 1 + $urandom_range(0, w - 2)) % w;
            if (nf >= 1) n[b1] = 1'b1;
            if (nf == 2) n[b2] = 1'b1;
            if (c == 2'd1) d = (m_enc(d, w) ^ n) | ($urandom & ~m);
            else if (c == 2'd2) n = n | ($urandom & ~m);
            run_op(c, ws, d, n, $sformatf("rand%0d c%0d w%0d", i, c, w));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
